axi_cache_arbiter: RTL and testbench

AXI_CACHE_ARBITER -- requirements
Module: axi_cache_arbiter

---
 rtl/axi_cache_arbiter.sv | 153 +++++++++++++++
 tb/tb_axi_cache_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cache_arbiter.sv
// Shares one AXI master between I-cache linefills, D-cache linefills and D-cache writebacks.
// Round-robin arbitration, with a same-line override that lets a writeback go ahead of a linefill.
module axi_cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  I_RdReq,
  input  logic [ADDR_WIDTH-1:0] I_RdAddr,
  output logic                  I_RdDone,
  output logic                  I_WordValid,
  input  logic                  D_RdReq,
  input  logic [ADDR_WIDTH-1:0] D_RdAddr,
  output logic                  D_RdDone,
  output logic                  D_WordValid,
  input  logic                  D_WrReq,
  input  logic [ADDR_WIDTH-1:0] D_WrAddr,
  input  logic [LINE_WIDTH-1:0] D_WrData,
  output logic                  D_WrDone,
  output logic [31:0]           RdData,
  output logic                  M_StartRead,
  output logic                  M_StartWrite,
  output logic [ADDR_WIDTH-1:0] M_ARAddr,
  output logic [ADDR_WIDTH-1:0] M_AWAddr,
  output logic [LINE_WIDTH-1:0] M_WriteData,
  input  logic [31:0]           M_ReadData,
  input  logic                  M_ValidReadData,
  input  logic                  M_ReadCompleted,
  input  logic                  M_WriteCompleted,
  output logic                  Timeout,
  output logic                  Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {NONE, IRD, DRD, DWR} owner_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  state_t                r_state;
  state_t                w_nextState;
  owner_t                r_owner;
  owner_t                r_lastGrant;
  owner_t                w_grant;
  logic [ADDR_WIDTH-1:0] r_arAddr;
  logic [ADDR_WIDTH-1:0] r_awAddr;
  logic [LINE_WIDTH-1:0] r_wrData;
  logic [9:0]            r_waitCnt;
  logic                  r_timeout;
  logic                  w_sameLine;
  logic                  w_complete;
  logic                  w_timeoutHit;

  // A writeback to the line being refilled must land first, otherwise the refill reads stale data.
  assign w_sameLine = (D_WrAddr[ADDR_WIDTH-1:5] == D_RdAddr[ADDR_WIDTH-1:5]);

  always_comb begin
    w_grant = NONE;
    if (D_WrReq && D_RdReq && w_sameLine) begin
      w_grant = DWR;
    end else begin
      case (r_lastGrant)
        IRD: begin
          if (D_RdReq)      w_grant = DRD;
          else if (D_WrReq) w_grant = DWR;
          else if (I_RdReq) w_grant = IRD;
        end
        DRD: begin
          if (D_WrReq)      w_grant = DWR;
          else if (I_RdReq) w_grant = IRD;
          else if (D_RdReq) w_grant = DRD;
        end
        default: begin
          if (I_RdReq)      w_grant = IRD;
          else if (D_RdReq) w_grant = DRD;
          else if (D_WrReq) w_grant = DWR;
        end
      endcase
    end
  end

  assign w_complete   = (r_owner == DWR) ? M_WriteCompleted : M_ReadCompleted;
  assign w_timeoutHit = (r_waitCnt == TIMEOUT_CNT);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_grant != NONE) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (w_complete || w_timeoutHit) w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Ownership, latched transaction data, wait counter and the sticky timeout flag.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_owner     <= NONE;
      r_lastGrant <= DWR;
      r_arAddr    <= '0;
      r_awAddr    <= '0;
      r_wrData    <= '0;
      r_waitCnt   <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != NONE) begin
            r_owner <= w_grant;
            if (w_grant == DWR) begin
              r_awAddr <= D_WrAddr;
              r_wrData <= D_WrData;
            end else if (w_grant == DRD) begin
              r_arAddr <= D_RdAddr;
            end else begin
              r_arAddr <= I_RdAddr;
            end
          end
        end
        ISSUE: r_waitCnt <= '0;
        WAIT: begin
          r_waitCnt <= r_waitCnt + 10'd1;
          if (w_timeoutHit && !w_complete) r_timeout <= 1'b1;
        end
        default: begin
          r_lastGrant <= r_owner;
          r_owner     <= NONE;
        end
      endcase
    end
  end

  assign Busy         = (r_state != IDLE);
  assign M_StartRead  = (r_state == ISSUE) && ((r_owner == IRD) || (r_owner == DRD));
  assign M_StartWrite = (r_state == ISSUE) && (r_owner == DWR);
  assign M_ARAddr     = r_arAddr;
  assign M_AWAddr     = r_awAddr;
  assign M_WriteData  = r_wrData;
  assign I_WordValid  = (r_state == WAIT) && (r_owner == IRD) && M_ValidReadData;
  assign D_WordValid  = (r_state == WAIT) && (r_owner == DRD) && M_ValidReadData;
  assign RdData       = (r_state == WAIT) ? M_ReadData : 32'd0;
  assign I_RdDone     = (r_state == DONE) && (r_owner == IRD);
  assign D_RdDone     = (r_state == DONE) && (r_owner == DRD);
  assign D_WrDone     = (r_state == DONE) && (r_owner == DWR);
  assign Timeout      = r_timeout;

endmodule

// File: tb/tb_axi_cache_arbiter.sv
// Self-checking bench for axi_cache_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level model of the arbitration and handshake timing.
module tb_axi_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 15;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          I_RdReq, D_RdReq, D_WrReq;
  logic [AW-1:0] I_RdAddr, D_RdAddr, D_WrAddr;
  logic [LW-1:0] D_WrData;
  logic          I_RdDone, D_RdDone, D_WrDone;
  logic          I_WordValid, D_WordValid;
  logic [31:0]   RdData;
  logic          M_StartRead, M_StartWrite;
  logic [AW-1:0] M_ARAddr, M_AWAddr;
  logic [LW-1:0] M_WriteData;
  logic [31:0]   M_ReadData;
  logic          M_ValidReadData, M_ReadCompleted, M_WriteCompleted;
  logic          Timeout, Busy;
  logic [2:0]    doneVec;

  int checkCount = 0;
  int failCount  = 0;
  int lastGrant;
  bit expTimeout;
  bit scrambleAddr;

  assign doneVec = {D_WrDone, D_RdDone, I_RdDone};

  axi_cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .I_RdReq(I_RdReq), .I_RdAddr(I_RdAddr), .I_RdDone(I_RdDone), .I_WordValid(I_WordValid),
    .D_RdReq(D_RdReq), .D_RdAddr(D_RdAddr), .D_RdDone(D_RdDone), .D_WordValid(D_WordValid),
    .D_WrReq(D_WrReq), .D_WrAddr(D_WrAddr), .D_WrData(D_WrData), .D_WrDone(D_WrDone),
    .RdData(RdData), .M_StartRead(M_StartRead), .M_StartWrite(M_StartWrite),
    .M_ARAddr(M_ARAddr), .M_AWAddr(M_AWAddr), .M_WriteData(M_WriteData),
    .M_ReadData(M_ReadData), .M_ValidReadData(M_ValidReadData),
    .M_ReadCompleted(M_ReadCompleted), .M_WriteCompleted(M_WriteCompleted),
    .Timeout(Timeout), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  // Requester index 0 = I-cache read, 1 = D-cache read, 2 = D-cache writeback.
  function automatic int predictGrant();
    bit req[3];
    req[0] = I_RdReq;
    req[1] = D_RdReq;
    req[2] = D_WrReq;
    if (D_RdReq && D_WrReq && (D_RdAddr[AW-1:5] == D_WrAddr[AW-1:5])) return 2;
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (lastGrant + k) % 3;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic checkResetOutputs();
    checkOutput("rstBusy", Busy, 1'b0);
    checkOutput("rstStart", {M_StartRead, M_StartWrite}, 2'b00);
    checkOutput("rstWordValid", {I_WordValid, D_WordValid}, 2'b00);
    checkOutput("rstDone", doneVec, 3'b000);
    checkOutput("rstTimeout", Timeout, 1'b0);
    checkOutput("rstRdData", RdData, 32'd0);
    checkOutput("rstArAddr", M_ARAddr, 32'd0);
    checkOutput("rstAwAddr", M_AWAddr, 32'd0);
    checkOutput("rstWrData", M_WriteData, 256'd0);
  endtask

  task automatic holdReset();
    Rst = 1'b0;
    #1;
    checkResetOutputs();
    repeat (2) begin
      nextCycle();
      checkOutput("rstHoldBusy", Busy, 1'b0);
      checkOutput("rstHoldDone", doneVec, 3'b000);
    end
    lastGrant  = 2;
    expTimeout = 1'b0;
    #1;
    Rst = 1'b1;
  endtask

  task automatic applyStimulus(input bit iReq, input bit dReq, input bit wReq);
    I_RdReq = iReq;
    D_RdReq = dReq;
    D_WrReq = wReq;
  endtask

  task automatic checkLatched(input bit isRead, input logic [31:0] expAddr, input logic [255:0] expData);
    if (isRead) begin
      checkOutput("arAddr", M_ARAddr, expAddr);
    end else begin
      checkOutput("awAddr", M_AWAddr, expAddr);
      checkOutput("writeData", M_WriteData, expData);
    end
  endtask

  // Entered in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
  task automatic serveTransaction(input int nWords, input bit useTimeout, input bit stray,
                                  input bit dropWinner, output int granted);
    int          win, seen, sent;
    bit          isRead, valid, finishNow;
    logic [31:0] expAddr;
    logic [255:0] expData;
    #1;
    checkOutput("idleBusy", Busy, 1'b0);
    checkOutput("idleDone", doneVec, 3'b000);
    win = predictGrant();
    granted = win;
    if (win < 0) begin
      nextCycle();
      return;
    end
    isRead  = (win != 2);
    expAddr = (win == 0) ? I_RdAddr : (win == 1) ? D_RdAddr : D_WrAddr;
    expData = D_WrData;
    nextCycle();
    if (scrambleAddr) begin
      I_RdAddr = $urandom;
      D_RdAddr = $urandom;
      D_WrAddr = $urandom;
      for (int i = 0; i < 8; i++) D_WrData[i*32 +: 32] = $urandom;
    end
    #1;
    checkOutput("issueBusy", Busy, 1'b1);
    checkOutput("startRead", M_StartRead, isRead);
    checkOutput("startWrite", M_StartWrite, !isRead);
    checkLatched(isRead, expAddr, expData);
    nextCycle();
    seen = 0;
    sent = 0;
    // Timeout fires in the WAIT cycle whose count equals TO, i.e. the (TO+1)th WAIT cycle.
    for (int cyc = 0; cyc <= TO + 1; cyc++) begin
      M_ReadCompleted  = 1'b0;
      M_WriteCompleted = 1'b0;
      M_ReadData       = $urandom;
      finishNow = !useTimeout && (sent >= nWords);
      valid     = !finishNow && ((cyc >= 6) || ($urandom_range(1) == 1));
      M_ValidReadData = valid;
      if (valid) sent++;
      if (finishNow) begin
        if (isRead) M_ReadCompleted = 1'b1;
        else        M_WriteCompleted = 1'b1;
      end else if (stray && cyc == 0) begin
        if (isRead) M_WriteCompleted = 1'b1;
        else        M_ReadCompleted = 1'b1;
      end
      #1;
      checkOutput("waitBusy", Busy, 1'b1);
      checkOutput("waitDone", doneVec, 3'b000);
      checkOutput("waitStart", {M_StartRead, M_StartWrite}, 2'b00);
      checkOutput("iWordValid", I_WordValid, valid && (win == 0));
      checkOutput("dWordValid", D_WordValid, valid && (win == 1));
      checkOutput("rdData", RdData, M_ReadData);
      checkOutput("waitTimeout", Timeout, expTimeout);
      checkLatched(isRead, expAddr, expData);
      seen += (win == 0) ? int'(I_WordValid) : (win == 1) ? int'(D_WordValid) : 0;
      nextCycle();
      if (finishNow || (useTimeout && cyc == TO)) break;
    end
    M_ValidReadData  = 1'b0;
    M_ReadCompleted  = 1'b0;
    M_WriteCompleted = 1'b0;
    if (useTimeout) expTimeout = 1'b1;
    #1;
    checkOutput("doneVec", doneVec, 3'b001 << win);
    checkOutput("doneBusy", Busy, 1'b1);
    checkOutput("doneTimeout", Timeout, expTimeout);
    checkLatched(isRead, expAddr, expData);
    if (isRead && !useTimeout) checkOutput("wordCount", seen, nWords);
    if (dropWinner) begin
      case (win)
        0:       I_RdReq = 1'b0;
        1:       D_RdReq = 1'b0;
        default: D_WrReq = 1'b0;
      endcase
    end
    lastGrant = win;
    nextCycle();
  endtask

  task automatic abortInWait();
    int win;
    #1;
    win = predictGrant();
    nextCycle();
    #1;
    checkOutput("abortStart", M_StartRead, 1'b1);
    nextCycle();
    M_ValidReadData = 1'b1;
    M_ReadData      = 32'hDEAD_BEEF;
    #1;
    checkOutput("abortBusy", Busy, 1'b1);
    checkOutput("abortWordValid", D_WordValid, win == 1);
    #2;
    holdReset();
    M_ValidReadData = 1'b0;
    M_ReadData      = 32'd0;
  endtask

  initial begin
    int g;
    Rst = 1'b0;
    applyStimulus(0, 0, 0);
    I_RdAddr = '0; D_RdAddr = '0; D_WrAddr = '0; D_WrData = '0;
    M_ReadData = '0; M_ValidReadData = 0; M_ReadCompleted = 0; M_WriteCompleted = 0;
    scrambleAddr = 1'b0;
    lastGrant = 2;
    expTimeout = 1'b0;
    @(posedge Clk);
    #3;
    holdReset();

    $display("[TB] single I-cache linefill of 8 words");
    I_RdAddr = 32'h1000;
    applyStimulus(1, 0, 0);
    serveTransaction(8, 0, 0, 1, g);
    checkOutput("firstGrant", g, 0);

    $display("[TB] all requesters held high from reset");
    @(posedge Clk);
    #3;
    holdReset();
    I_RdAddr = 32'h0100; D_RdAddr = 32'h3000; D_WrAddr = 32'h4000;
    for (int i = 0; i < 8; i++) D_WrData[i*32 +: 32] = 32'hA5A5_0000 + i;
    applyStimulus(1, 1, 1);
    for (int t = 0; t < 4; t++) begin
      serveTransaction(1 + t, 0, 0, 0, g);
      checkOutput("rrOrder", g, t % 3);
    end

    $display("[TB] same-line writeback overrides round-robin");
    D_RdAddr = 32'h2004;
    D_WrAddr = 32'h2010;
    applyStimulus(0, 1, 1);
    serveTransaction(2, 0, 0, 1, g);
    checkOutput("overrideGrant", g, 2);
    serveTransaction(3, 0, 0, 1, g);
    checkOutput("afterOverride", g, 1);

    $display("[TB] writeback ignores read completion");
    applyStimulus(0, 0, 1);
    serveTransaction(3, 0, 1, 1, g);
    checkOutput("strayGrant", g, 2);

    $display("[TB] timeout then normal service");
    applyStimulus(1, 0, 0);
    serveTransaction(0, 1, 0, 1, g);
    checkOutput("timeoutGrant", g, 0);
    applyStimulus(0, 1, 0);
    serveTransaction(4, 0, 0, 1, g);
    checkOutput("postTimeoutGrant", g, 1);

    $display("[TB] reset during WAIT");
    @(posedge Clk);
    #3;
    holdReset();
    applyStimulus(1, 0, 0);
    serveTransaction(2, 0, 0, 1, g);
    D_RdAddr = 32'h5000;
    applyStimulus(1, 1, 0);
    abortInWait();
    serveTransaction(2, 0, 0, 1, g);
    checkOutput("postResetGrant", g, 0);

    $display("[TB] randomized transactions");
    scrambleAddr = 1'b1;
    repeat (40) begin
      I_RdAddr = $urandom;
      D_RdAddr = $urandom;
      D_WrAddr = $urandom;
      for (int i = 0; i < 8; i++) D_WrData[i*32 +: 32] = $urandom;
      if ($urandom_range(3) == 0) D_WrAddr[AW-1:5] = D_RdAddr[AW-1:5];
      applyStimulus($urandom_range(1), $urandom_range(1), $urandom_range(1));
      serveTransaction($urandom_range(8, 1), $urandom_range(9) == 0, $urandom_range(3) == 0,
                       $urandom_range(1), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
